// File: rtl/ps2_kc_pkg.sv
// Shared constants, state type and scan-code lookup functions for the
// PS/2 keycode translator. Keycodes are 8 bits: bit 7 = break, bits 6:0 = key number.
package ps2_kc_pkg;

    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Keyboard control/response bytes that never start a key sequence
    localparam logic [7:0] PS2_CTRL_LIST [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA,
                                                 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    localparam logic [6:0] KC_PAUSE  = 7'd126;
    localparam logic [6:0] KC_LSHIFT = 7'd44;
    localparam logic [6:0] KC_RSHIFT = 7'd57;
    localparam logic [6:0] KC_LCTRL  = 7'd58;
    localparam logic [6:0] KC_LALT   = 7'd60;
    localparam logic [6:0] KC_LGUI   = 7'd59;
    localparam logic [6:0] KC_RCTRL  = 7'd64;
    localparam logic [6:0] KC_RALT   = 7'd62;
    localparam logic [6:0] KC_RGUI   = 7'd63;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BRK     = 3'd1,
        ST_EXT     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_EMIT    = 3'd5
    } kc_state_e;

    function automatic logic ps2_is_ctrl(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b == PS2_CTRL_LIST[i]) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    function automatic logic [6:0] ps2_set2_basic(input logic [7:0] b);
        case (b)
            8'h0E: return 7'd1;   8'h16: return 7'd2;   8'h1E: return 7'd3;
            8'h26: return 7'd4;   8'h25: return 7'd5;   8'h2E: return 7'd6;
            8'h36: return 7'd7;   8'h3D: return 7'd8;   8'h3E: return 7'd9;
            8'h46: return 7'd10;  8'h45: return 7'd11;  8'h4E: return 7'd12;
            8'h55: return 7'd13;  8'h66: return 7'd15;  8'h0D: return 7'd16;
            8'h15: return 7'd17;  8'h1D: return 7'd18;  8'h24: return 7'd19;
            8'h2D: return 7'd20;  8'h2C: return 7'd21;  8'h35: return 7'd22;
            8'h3C: return 7'd23;  8'h43: return 7'd24;  8'h44: return 7'd25;
            8'h4D: return 7'd26;  8'h54: return 7'd27;  8'h5B: return 7'd28;
            8'h5D: return 7'd29;  8'h58: return 7'd30;  8'h1C: return 7'd31;
            8'h1B: return 7'd32;  8'h23: return 7'd33;  8'h2B: return 7'd34;
            8'h34: return 7'd35;  8'h33: return 7'd36;  8'h3B: return 7'd37;
            8'h42: return 7'd38;  8'h4B: return 7'd39;  8'h4C: return 7'd40;
            8'h52: return 7'd41;  8'h5A: return 7'd43;  8'h12: return 7'd44;
            8'h61: return 7'd45;  8'h1A: return 7'd46;  8'h22: return 7'd47;
            8'h21: return 7'd48;  8'h2A: return 7'd49;  8'h32: return 7'd50;
            8'h31: return 7'd51;  8'h3A: return 7'd52;  8'h41: return 7'd53;
            8'h49: return 7'd54;  8'h4A: return 7'd55;  8'h59: return 7'd57;
            8'h14: return 7'd58;  8'h11: return 7'd60;  8'h29: return 7'd61;
            8'h77: return 7'd90;  8'h6C: return 7'd91;  8'h6B: return 7'd92;
            8'h69: return 7'd93;  8'h75: return 7'd96;  8'h73: return 7'd97;
            8'h72: return 7'd98;  8'h70: return 7'd99;  8'h7C: return 7'd100;
            8'h7D: return 7'd101; 8'h74: return 7'd102; 8'h7A: return 7'd103;
            8'h71: return 7'd104; 8'h7B: return 7'd105; 8'h79: return 7'd106;
            8'h76: return 7'd110; 8'h05: return 7'd112; 8'h06: return 7'd113;
            8'h04: return 7'd114; 8'h0C: return 7'd115; 8'h03: return 7'd116;
            8'h0B: return 7'd117; 8'h83: return 7'd118; 8'h0A: return 7'd119;
            8'h01: return 7'd120; 8'h09: return 7'd121; 8'h78: return 7'd122;
            8'h07: return 7'd123; 8'h7E: return 7'd125;
            default: return 7'd0;
        endcase
    endfunction

    // Fake shifts (E0 12, E0 59) fall into the default and map to 0
    function automatic logic [6:0] ps2_set2_ext(input logic [7:0] b);
        case (b)
            8'h11: return 7'd62;  8'h14: return 7'd64;  8'h1F: return 7'd59;
            8'h27: return 7'd63;  8'h2F: return 7'd65;  8'h69: return 7'd81;
            8'h70: return 7'd75;  8'h71: return 7'd76;  8'h6B: return 7'd79;
            8'h6C: return 7'd80;  8'h75: return 7'd83;  8'h72: return 7'd84;
            8'h7D: return 7'd85;  8'h7A: return 7'd86;  8'h74: return 7'd89;
            8'h4A: return 7'd95;  8'h5A: return 7'd108; 8'h7C: return 7'd124;
            8'h15: return 7'd126;
            default: return 7'd0;
        endcase
    endfunction

    // One-hot position of a modifier key inside the mods vector
    function automatic logic [7:0] kc_mod_mask(input logic [6:0] k);
        case (k)
            KC_LSHIFT: return 8'h01;
            KC_RSHIFT: return 8'h02;
            KC_LCTRL:  return 8'h04;
            KC_LALT:   return 8'h08;
            KC_LGUI:   return 8'h10;
            KC_RCTRL:  return 8'h20;
            KC_RALT:   return 8'h40;
            KC_RGUI:   return 8'h80;
            default:   return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/kc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module kc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_s;
    logic             push_s;

    assign empty     = (count_r == {CW{1'b0}});
    assign full      = (count_r == CW'(DEPTH));
    assign pop_s     = pop & ~empty;
    assign push_s    = push & (~full | pop_s);
    assign count     = count_r;
    assign head_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents beyond the count are don't-care
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_keycode_xlat_fifo.sv
// PS/2 scan-code set 2 to keycode translator with keycode FIFO, key-down
// bitmap for typematic-repeat suppression, fake-shift and control-byte
// filtering, and sticky overflow flag.
// Optional: define PS2_KC_MODSTATE_EN to track modifier down-state on mods_o.
module ps2_keycode_xlat_fifo
    import ps2_kc_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int SUPPRESS_REPEAT = 1,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    scancode_i,
    input  logic          scodevalid_i,
    input  logic          clear_i,
    output logic [7:0]    kc_data_o,
    output logic          kc_valid_o,
    input  logic          kc_ready_i,
    output logic [CW-1:0] fifo_count_o,
    output logic          overflow_o,
    output logic [7:0]    mods_o
);

    kc_state_e    state_r;
    logic [2:0]   pause_cnt_r;
    logic [6:0]   k_r;
    logic         brk_r;
    logic         pause_r;
    logic [127:0] bitmap_r;
    logic         push_r;
    logic [7:0]   push_data_r;
    logic         overflow_r;
    logic         fifo_full_s;
    logic         fifo_empty_s;
    logic         pop_s;

    assign kc_valid_o = ~fifo_empty_s;
    assign pop_s      = kc_valid_o & kc_ready_i;
    assign overflow_o = overflow_r;

    // Prefix parser: collects a key sequence, then spends one EMIT cycle deciding what to push
    always_ff @(posedge clk) begin
        if (!resetn || clear_i) begin
            state_r     <= ST_IDLE;
            pause_cnt_r <= 3'd0;
            k_r         <= 7'd0;
            brk_r       <= 1'b0;
            pause_r     <= 1'b0;
            bitmap_r    <= 128'd0;
            push_r      <= 1'b0;
            push_data_r <= 8'd0;
        end else begin
            push_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (scodevalid_i) begin
                        if (scancode_i == PS2_BRK) begin
                            state_r <= ST_BRK;
                        end else if (scancode_i == PS2_EXT) begin
                            state_r <= ST_EXT;
                        end else if (scancode_i == PS2_PAUSE) begin
                            state_r     <= ST_PAUSE;
                            pause_cnt_r <= 3'd7;
                        end else if (ps2_is_ctrl(scancode_i)) begin
                            state_r <= ST_IDLE;
                        end else begin
                            k_r     <= ps2_set2_basic(scancode_i);
                            brk_r   <= 1'b0;
                            pause_r <= 1'b0;
                            state_r <= ST_EMIT;
                        end
                    end
                end
                ST_BRK: begin
                    if (scodevalid_i) begin
                        k_r     <= ps2_set2_basic(scancode_i);
                        brk_r   <= 1'b1;
                        pause_r <= 1'b0;
                        state_r <= ST_EMIT;
                    end
                end
                ST_EXT: begin
                    if (scodevalid_i) begin
                        if (scancode_i == PS2_BRK) begin
                            state_r <= ST_EXT_BRK;
                        end else begin
                            k_r     <= ps2_set2_ext(scancode_i);
                            brk_r   <= 1'b0;
                            pause_r <= 1'b0;
                            state_r <= ST_EMIT;
                        end
                    end
                end
                ST_EXT_BRK: begin
                    if (scodevalid_i) begin
                        k_r     <= ps2_set2_ext(scancode_i);
                        brk_r   <= 1'b1;
                        pause_r <= 1'b0;
                        state_r <= ST_EMIT;
                    end
                end
                ST_PAUSE: begin
                    // Pause is an 8-byte make-only sequence; the last byte produces the keycode
                    if (scodevalid_i) begin
                        if (pause_cnt_r == 3'd1) begin
                            k_r     <= KC_PAUSE;
                            brk_r   <= 1'b0;
                            pause_r <= 1'b1;
                            state_r <= ST_EMIT;
                        end else begin
                            pause_cnt_r <= pause_cnt_r - 3'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    state_r <= ST_IDLE;
                    if (k_r != 7'd0) begin
                        if (pause_r) begin
                            push_r      <= 1'b1;
                            push_data_r <= {1'b0, k_r};
                        end else begin
                            // Bitmap tracks the key even when the FIFO later drops the push
                            bitmap_r[k_r] <= ~brk_r;
                            if (!brk_r && (SUPPRESS_REPEAT != 0) && bitmap_r[k_r]) begin
                                push_r <= 1'b0;
                            end else begin
                                push_r      <= 1'b1;
                                push_data_r <= {brk_r, k_r};
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: a push arrived while full with no pop to make room
    always_ff @(posedge clk) begin
        if (!resetn || clear_i) begin
            overflow_r <= 1'b0;
        end else if (push_r && fifo_full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

`ifdef PS2_KC_MODSTATE_EN
    logic [7:0] mods_r;

    // Modifier down-state follows the same EMIT decision as the bitmap
    always_ff @(posedge clk) begin
        if (!resetn || clear_i) begin
            mods_r <= 8'd0;
        end else if ((state_r == ST_EMIT) && !pause_r && (k_r != 7'd0)) begin
            if (brk_r) begin
                mods_r <= mods_r & ~kc_mod_mask(k_r);
            end else begin
                mods_r <= mods_r | kc_mod_mask(k_r);
            end
        end else begin
            mods_r <= mods_r;
        end
    end

    assign mods_o = mods_r;
`else
    assign mods_o = 8'd0;
`endif

    kc_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear_i),
        .push      (push_r),
        .push_data (push_data_r),
        .pop       (kc_ready_i),
        .head_data (kc_data_o),
        .count     (fifo_count_o),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule
